itoh_tsujii_sequencer: RTL

Control sequencer for Itoh-Tsujii inversion in GF(2^283). It sits directly downstream of the 11-entry addition-chain ROM. For each chain step it reads the squaring count and issues squaring enables and multiply requests to the field datapath. It finishes with one final squaring and signals done. It drives control only; the T, B and a operand registers live in the datapath.

---
 rtl/itoh_tsujii_pkg.sv | 20 ++
 rtl/itoh_tsujii_sequencer_sq_down_counter.sv | 30 +++
 rtl/itoh_tsujii_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/itoh_tsujii_pkg.sv
// Shared definitions for the GF(2^283) Itoh-Tsujii inversion control path and datapath.
package itoh_tsujii_pkg;

  localparam int NUM_STEPS = 11;
  localparam int CNT_W     = 8;
  localparam int FIELD_M   = 283;
  localparam int STEP_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    SQUARE,
    MUL_REQ,
    MUL_WAIT,
    FINAL_SQ,
    DONE
  } itoh_state_t;

endpackage

// File: rtl/itoh_tsujii_sequencer_sq_down_counter.sv
// Squaring-run counter: loaded with a chain step's squaring count, flags the last squaring.
module sq_down_counter
  import itoh_tsujii_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count;

  // Saturates at zero so a stray decrement can never wrap into a huge run.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/itoh_tsujii_sequencer.sv
// Control FSM for Itoh-Tsujii inversion: walks the addition-chain ROM and strobes the
// field datapath with load, save, square and multiply commands.
module itoh_tsujii_sequencer
  import itoh_tsujii_pkg::*;
#(
  parameter int NUM_STEPS = itoh_tsujii_pkg::NUM_STEPS,
  parameter int CNT_W     = itoh_tsujii_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       rom_addr,
  input  logic [CNT_W-1:0] rom_data,
  output logic             load_t,
  output logic             save_b,
  output logic             sq_en,
  output logic             mul_start,
  output logic             mul_sel,
  input  logic             mul_done
);

  itoh_state_t       state;
  logic [STEP_W-1:0] step;
  logic              sq_last;
  logic              rom_is_one;

  assign rom_is_one = (rom_data == CNT_W'(1));

  sq_down_counter #(.W(CNT_W)) u_sq_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == FETCH),
    .load_val (rom_data),
    .dec      (state == SQUARE),
    .last     (sq_last)
  );

  // A step value of 1 is the "square then multiply by a" step; every other step
  // snapshots T into B first and multiplies by that snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      mul_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          step  <= '0;
          state <= FETCH;
        end
        FETCH: begin
          mul_sel <= rom_is_one;
          state   <= (rom_data == '0) ? MUL_REQ : SQUARE;
        end
        SQUARE: begin
          if (sq_last) state <= MUL_REQ;
        end
        MUL_REQ: begin
          state <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mul_done) begin
            if (step == STEP_W'(NUM_STEPS - 1)) begin
              mul_sel <= 1'b0;
              state   <= FINAL_SQ;
            end else begin
              step  <= step + STEP_W'(1);
              state <= FETCH;
            end
          end
        end
        FINAL_SQ: begin
          state <= DONE;
        end
        DONE: begin
          step  <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign load_t    = (state == LOAD);
  assign sq_en     = (state == SQUARE) || (state == FINAL_SQ);
  assign mul_start = (state == MUL_REQ);
  // save_b follows the combinational ROM word of the step being fetched.
  assign save_b    = (state == FETCH) && !rom_is_one;
  assign rom_addr  = step;

endmodule
